// File: rtl/tim_cfg_seq_if.sv
// APB write bundle between the timer config sequencer and the timer port.
// The master drives the request; the slave answers with pready/pslverr.
interface tim_cfg_seq_if;
  logic        tim_psel;
  logic        tim_penable;
  logic        tim_pwrite;
  logic [31:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic        tim_pready;
  logic        tim_pslverr;

  modport master (
    output tim_psel,
    output tim_penable,
    output tim_pwrite,
    output tim_paddr,
    output tim_pwdata,
    output tim_pstrb,
    input  tim_pready,
    input  tim_pslverr
  );

  modport slave (
    input  tim_psel,
    input  tim_penable,
    input  tim_pwrite,
    input  tim_paddr,
    input  tim_pwdata,
    input  tim_pstrb,
    output tim_pready,
    output tim_pslverr
  );
endinterface

// File: rtl/tim_cfg_seq.sv
// APB master that programs and starts the timer with a fixed
// seven-write sequence, with slave-error and no-response abort.
module tim_cfg_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [11:0] TCR_OFS   = 12'h000,
  parameter logic [11:0] TDR0_OFS  = 12'h004,
  parameter logic [11:0] TDR1_OFS  = 12'h008,
  parameter logic [11:0] TCMP0_OFS = 12'h00C,
  parameter logic [11:0] TCMP1_OFS = 12'h010,
  parameter logic [11:0] TIER_OFS  = 12'h014,
  parameter int unsigned WAIT_MAX  = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [63:0] cfg_cnt_init,
  input  logic [63:0] cfg_cmp,
  input  logic        cfg_div_en,
  input  logic [3:0]  cfg_div_val,
  input  logic        cfg_int_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [2:0]  err_step,
  tim_cfg_seq_if.master apb
);

  localparam int unsigned WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t         state;
  logic [2:0]     step;
  logic [WW-1:0]  wait_cnt;
  logic [63:0]    cnt_q;
  logic [63:0]    cmp_q;
  logic           div_en_q;
  logic [3:0]     div_val_q;
  logic           int_en_q;

  function automatic logic [31:0] addr_of(input logic [2:0] s);
    logic [11:0] ofs;
    case (s)
      3'd1:    ofs = TDR0_OFS;
      3'd2:    ofs = TDR1_OFS;
      3'd3:    ofs = TCMP0_OFS;
      3'd4:    ofs = TCMP1_OFS;
      3'd5:    ofs = TIER_OFS;
      default: ofs = TCR_OFS;
    endcase
    return BASE_ADDR + {20'b0, ofs};
  endfunction

  // Step 0 writes zero, so it is safe to use before cfg is latched.
  function automatic logic [31:0] data_of(input logic [2:0] s);
    logic [31:0] d;
    case (s)
      3'd1:    d = cnt_q[31:0];
      3'd2:    d = cnt_q[63:32];
      3'd3:    d = cmp_q[31:0];
      3'd4:    d = cmp_q[63:32];
      3'd5:    d = {31'b0, int_en_q};
      3'd6:    d = {20'b0, div_val_q, 6'b0, div_en_q, 1'b1};
      default: d = 32'h0;
    endcase
    return d;
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      step            <= 3'd0;
      wait_cnt        <= '0;
      cnt_q           <= 64'h0;
      cmp_q           <= 64'h0;
      div_en_q        <= 1'b0;
      div_val_q       <= 4'h0;
      int_en_q        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      err_code        <= 2'b00;
      err_step        <= 3'd0;
      apb.tim_psel    <= 1'b0;
      apb.tim_penable <= 1'b0;
      apb.tim_pwrite  <= 1'b0;
      apb.tim_paddr   <= 32'h0;
      apb.tim_pwdata  <= 32'h0;
      apb.tim_pstrb   <= 4'h0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt_q           <= cfg_cnt_init;
            cmp_q           <= cfg_cmp;
            div_en_q        <= cfg_div_en;
            div_val_q       <= cfg_div_val;
            int_en_q        <= cfg_int_en;
            err_code        <= 2'b00;
            err_step        <= 3'd0;
            step            <= 3'd0;
            busy            <= 1'b1;
            state           <= SETUP;
            apb.tim_psel    <= 1'b1;
            apb.tim_penable <= 1'b0;
            apb.tim_pwrite  <= 1'b1;
            apb.tim_pstrb   <= 4'hF;
            apb.tim_paddr   <= addr_of(3'd0);
            apb.tim_pwdata  <= 32'h0;
          end
        end
        SETUP: begin
          apb.tim_penable <= 1'b1;
          wait_cnt        <= '0;
          state           <= ACCESS;
        end
        ACCESS: begin
          if (apb.tim_pready && !apb.tim_pslverr && step != 3'd6) begin
            step            <= step + 3'd1;
            apb.tim_penable <= 1'b0;
            apb.tim_paddr   <= addr_of(step + 3'd1);
            apb.tim_pwdata  <= data_of(step + 3'd1);
            state           <= SETUP;
          end else if (apb.tim_pready || wait_cnt == WAIT_LAST) begin
            // Completion and both abort flavours all release the bus.
            apb.tim_psel    <= 1'b0;
            apb.tim_penable <= 1'b0;
            apb.tim_pwrite  <= 1'b0;
            apb.tim_paddr   <= 32'h0;
            apb.tim_pwdata  <= 32'h0;
            apb.tim_pstrb   <= 4'h0;
            busy            <= 1'b0;
            state           <= IDLE;
            if (apb.tim_pready && !apb.tim_pslverr) begin
              done <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= apb.tim_pready ? 2'b01 : 2'b10;
              err_step <= step;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tim_cfg_seq.sv
// Directed and randomized bench for tim_cfg_seq against a simple
// write-list model of the timer programming sequence.
module tb_tim_cfg_seq;
  localparam int WAIT_MAX = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] cnt = 64'h0;
  logic [63:0] cmp = 64'h0;
  logic        div_en = 1'b0;
  logic [3:0]  div_val = 4'h0;
  logic        int_en = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [2:0]  err_step;

  tim_cfg_seq_if bus ();

  tim_cfg_seq #(.WAIT_MAX(WAIT_MAX)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .start        (start),
    .cfg_cnt_init (cnt),
    .cfg_cmp      (cmp),
    .cfg_div_en   (div_en),
    .cfg_div_val  (div_val),
    .cfg_int_en   (int_en),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .err_step     (err_step),
    .apb          (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int waits[7] = '{0, 0, 0, 0, 0, 0, 0};
  int err_idx = -1;

  logic [31:0] wa[8];
  logic [31:0] wd[8];
  int          wr_cnt = 0;
  int          proto_bad = 0;
  int          acc_n = 0;
  bit          in_run = 1'b0;
  logic [31:0] ca = 32'h0;
  logic [31:0] cd = 32'h0;

  // Slave: inserts waits[k] stall cycles on write k, errors on err_idx,
  // records each completed write and flags unstable/illegal bus values.
  always @(negedge clk) begin
    bus.tim_pready  = 1'b0;
    bus.tim_pslverr = 1'b0;
    if (!busy) in_run = 1'b0;
    if (!bus.tim_psel) begin
      acc_n = 0;
      if (bus.tim_penable !== 1'b0 || bus.tim_paddr !== 32'h0 ||
          bus.tim_pwdata !== 32'h0 || bus.tim_pstrb !== 4'h0)
        proto_bad++;
    end else begin
      if (!in_run) begin
        in_run = 1'b1;
        wr_cnt = 0;
      end
      if (bus.tim_pwrite !== 1'b1 || bus.tim_pstrb !== 4'hF)
        proto_bad++;
      if (bus.tim_penable) begin
        if (acc_n == 0) begin
          ca = bus.tim_paddr;
          cd = bus.tim_pwdata;
        end else if (bus.tim_paddr !== ca || bus.tim_pwdata !== cd) begin
          proto_bad++;
        end
        if (wr_cnt < 7 && acc_n >= waits[wr_cnt]) begin
          bus.tim_pready  = 1'b1;
          bus.tim_pslverr = (wr_cnt == err_idx);
          wa[wr_cnt] = ca;
          wd[wr_cnt] = cd;
          wr_cnt++;
          acc_n = 0;
        end else begin
          acc_n++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic rand_cfg();
    cnt     = {$urandom, $urandom};
    cmp     = {$urandom, $urandom};
    div_en  = 1'($urandom);
    div_val = 4'($urandom);
    int_en  = 1'($urandom);
  endtask

  // kind: 0 = clean run, 1 = slave error on write e, 2 = no answer on write e
  task automatic run(input int kind, input int e, input bit poke);
    logic [31:0] ea[7];
    logic [31:0] ed[7];
    int exp_cyc;
    int exp_n;
    int sp;
    int n;
    ea = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h0};
    ed[0] = 32'h0;
    ed[1] = cnt[31:0];
    ed[2] = cnt[63:32];
    ed[3] = cmp[31:0];
    ed[4] = cmp[63:32];
    ed[5] = int_en ? 32'd1 : 32'd0;
    ed[6] = 32'(div_val) * 32'd256 + (div_en ? 32'd2 : 32'd0) + 32'd1;
    err_idx = (kind == 1) ? e : -1;
    if (kind == 2) waits[e] = 1000;
    sp = 0;
    for (int k = 0; k < e; k++) sp += waits[k];
    if (kind == 0) begin
      exp_cyc = 14;
      for (int k = 0; k < 7; k++) exp_cyc += waits[k];
      exp_n = 7;
    end else if (kind == 1) begin
      exp_cyc = 2 * e + 2 + sp + waits[e];
      exp_n = e + 1;
    end else begin
      exp_cyc = 2 * e + sp + WAIT_MAX + 1;
      exp_n = e;
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_setup", {bus.tim_psel, bus.tim_penable, busy}, 3'b101);
    n = 0;
    while (!(done || err) && n < 400) begin
      @(negedge clk);
      n++;
      if (poke && n == 3) begin
        start = 1'b1;
        rand_cfg();
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("cycles", 64'(n), 64'(exp_cyc));
    chk("done", 64'(done), (kind == 0) ? 64'd1 : 64'd0);
    chk("err", 64'(err), (kind != 0) ? 64'd1 : 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    chk("err_code", 64'(err_code),
        (kind == 1) ? 64'd1 : (kind == 2) ? 64'd2 : 64'd0);
    chk("err_step", 64'(err_step), (kind != 0) ? 64'(e) : 64'd0);
    chk("nwrites", 64'(wr_cnt), 64'(exp_n));
    for (int k = 0; k < exp_n && k < wr_cnt; k++) begin
      chk($sformatf("addr%0d", k), 64'(wa[k]), 64'(ea[k]));
      chk($sformatf("data%0d", k), 64'(wd[k]), 64'(ed[k]));
    end
    @(negedge clk);
    chk("pulse_low", {done, err, busy}, 3'b000);
    chk("code_held", 64'(err_code),
        (kind == 1) ? 64'd1 : (kind == 2) ? 64'd2 : 64'd0);
    chk("protocol", 64'(proto_bad), 64'd0);
    waits = '{0, 0, 0, 0, 0, 0, 0};
    err_idx = -1;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outs",
        {busy, done, err, err_code, err_step, bus.tim_psel,
         bus.tim_penable, bus.tim_pwrite, bus.tim_pstrb},
        64'h0);
    chk("reset_bus", {bus.tim_paddr, bus.tim_pwdata}, 64'h0);

    cnt = 64'h0000_0001_0000_0002;
    cmp = 64'h5;
    div_en = 1'b1;
    div_val = 4'd3;
    int_en = 1'b1;
    run(0, 6, 1'b0);
    chk("tcr_final", 64'(wd[6]), 64'h303);

    rand_cfg();
    waits[2] = 3;
    run(0, 6, 1'b0);

    rand_cfg();
    run(1, 4, 1'b0);

    rand_cfg();
    run(2, 0, 1'b0);

    rand_cfg();
    run(0, 6, 1'b1);

    rand_cfg();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(bus.tim_psel && bus.tim_penable &&
             bus.tim_paddr == 32'hC) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_step3", 64'(n < 100), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs",
        {busy, done, err, err_code, err_step, bus.tim_psel,
         bus.tim_penable, bus.tim_pwrite, bus.tim_pstrb},
        64'h0);
    chk("midrst_bus", {bus.tim_paddr, bus.tim_pwdata}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_cfg();
    run(0, 6, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rand_cfg();
      for (int k = 0; k < 7; k++) waits[k] = $urandom_range(0, 3);
      run(i % 3, $urandom_range(0, 6), i == 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
